// File: rtl/apb_master_arbiter_pkg.sv
// Shared APB widths, requester limit and the arbiter FSM state type.
package apb_master_arbiter_pkg;

  localparam int APB_ADDR_WIDTH  = 32;
  localparam int APB_DATA_WIDTH  = 32;
  localparam int APB_ARB_MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_e;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester command bundle plus APB master pins of the shared arbiter.
interface apb_master_arbiter_if
  import apb_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ-1:0]                req_write;
  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]                done;
  logic [NUM_REQ-1:0]                err;
  logic [APB_DATA_WIDTH-1:0]         rdata;

  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [APB_DATA_WIDTH-1:0] PWDATA;
  logic [APB_DATA_WIDTH-1:0] PRDATA;
  logic                      PREADY;

  // Arbiter side: consumes requests, drives the APB bus.
  modport master (
    input  req, req_write, req_addr, req_wdata, PRDATA, PREADY,
    output done, err, rdata, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  // Requesters and APB slave side.
  modport slave (
    output req, req_write, req_addr, req_wdata, PRDATA, PREADY,
    input  done, err, rdata, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_master_arbiter_rr.sv
// Combinational round-robin search: first eligible requester at or after ptr_i.
module apb_rr_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         mask_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       valid_o
);

  localparam int IDXW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] elig;

  assign elig = req_i & ~mask_i;

  // One spare bit on pos keeps ptr + offset from wrapping before the modulo.
  always_comb begin
    logic [IDXW:0]   pos;
    logic [IDXW-1:0] cand;
    logic            found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr_i} + (IDXW+1)'(k);
      if (pos >= (IDXW+1)'(NUM_REQ)) begin
        pos = pos - (IDXW+1)'(NUM_REQ);
      end
      cand = pos[IDXW-1:0];
      if (!found && elig[cand]) begin
        found       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port between NUM_REQ requesters.
// Optional PREADY timeout abort is enabled by defining APB_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | bus free, PSEL=0, waiting for an unmasked request
//   SETUP  | PSEL=1, PENABLE=0, command latched for the granted requester
//   ACCESS | PSEL=1, PENABLE=1, waiting for PREADY (or timeout)
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 apbClk,
  input  logic                 rst,
  apb_master_arbiter_if.master bus
);

  localparam int IDXW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > APB_ARB_MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("apb_master_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  apb_arb_state_e            state_q;
  logic [IDXW-1:0]           ptr_q;
  logic [NUM_REQ-1:0]        own_q;
  logic [NUM_REQ-1:0]        done_q;
  logic                      psel_q;
  logic                      penable_q;
  logic                      pwrite_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;

  logic [NUM_REQ-1:0]        arb_mask;
  logic [NUM_REQ-1:0]        arb_gnt;
  logic [IDXW-1:0]           arb_idx;
  logic                      arb_valid;
  logic                      grant_en;
  logic [IDXW-1:0]           ptr_d;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]          wait_q;
  logic [NUM_REQ-1:0]        err_q;
  logic                      timeout_hit;

  assign timeout_hit = (state_q == ACCESS) && !bus.PREADY &&
                       (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // A requester being acknowledged this cycle cannot re-win; the current
  // owner is also excluded when choosing a back-to-back successor.
  assign arb_mask = done_q | ((state_q == ACCESS) ? own_q : '0);

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i   (bus.req),
    .mask_i  (arb_mask),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign grant_en = arb_valid &&
                    ((state_q == IDLE) || (state_q == ACCESS && bus.PREADY));
  assign ptr_d    = (arb_idx == IDXW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

  always_ff @(posedge apbClk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      own_q     <= '0;
      done_q    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
`ifdef APB_TIMEOUT_EN
      wait_q    <= '0;
      err_q     <= '0;
`endif
    end else begin
      done_q <= '0;
`ifdef APB_TIMEOUT_EN
      err_q  <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_q    <= '0;
`endif
        end
        ACCESS: begin
          if (bus.PREADY) begin
            done_q    <= own_q;
            penable_q <= 1'b0;
            if (!pwrite_q) begin
              rdata_q <= bus.PRDATA;
            end
            if (arb_valid) begin
              state_q <= SETUP;
            end else begin
              psel_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
`ifdef APB_TIMEOUT_EN
          else if (timeout_hit) begin
            done_q    <= own_q;
            err_q     <= own_q;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase

      // Command capture for a fresh grant, from IDLE or chained off a completion.
      if (grant_en) begin
        own_q    <= arb_gnt;
        ptr_q    <= ptr_d;
        pwrite_q <= bus.req_write[arb_idx];
        paddr_q  <= bus.req_addr[arb_idx*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        pwdata_q <= bus.req_wdata[arb_idx*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      end
    end
  end

  assign bus.done    = done_q;
  assign bus.rdata   = rdata_q;
  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;

`ifdef APB_TIMEOUT_EN
  assign bus.err = err_q;
`else
  assign bus.err = '0;
`endif

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed cases plus random traffic vs a transfer-level model.
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  apb_master_arbiter_if #(.NUM_REQ(N)) bus ();

  apb_master_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .apbClk (clk),
    .rst    (rst_n),
    .bus    (bus.master)
  );

  // stimulus
  logic [N-1:0]  s_req;
  logic [N-1:0]  s_wr;
  logic [AW-1:0] s_addr [N];
  logic [DW-1:0] s_wdata [N];
  logic          s_ready;
  logic [DW-1:0] s_prdata;

  // transfer-level model: a bus that is busy or free, one owner, a phase flag
  logic          m_busy;
  logic          m_enable;
  logic          m_pwrite;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata;
  logic [DW-1:0] m_rdata;
  logic [N-1:0]  m_done;
  logic [N-1:0]  m_err;
  int            m_owner;
  int            m_ptr;
  int            m_waits;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic apply();
    bus.req       = s_req;
    bus.req_write = s_wr;
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*AW +: AW]  = s_addr[i];
      bus.req_wdata[i*DW +: DW] = s_wdata[i];
    end
    bus.PREADY = s_ready;
    bus.PRDATA = s_prdata;
  endtask

  function automatic int rr_pick(input logic [N-1:0] elig, input int from);
    for (int k = 0; k < N; k++) begin
      if (elig[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  function automatic int first_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_enable = 0; m_pwrite = 0; m_paddr = '0; m_pwdata = '0;
    m_rdata = '0; m_done = '0; m_err = '0; m_owner = 0; m_ptr = 0; m_waits = 0;
  endtask

  task automatic model_start(input int p);
    m_owner  = p;
    m_ptr    = (p + 1) % N;
    m_busy   = 1;
    m_enable = 0;
    m_pwrite = s_wr[p];
    m_paddr  = s_addr[p];
    m_pwdata = s_wdata[p];
  endtask

  // Advance the model across one rising edge using the inputs about to be sampled.
  task automatic model_step();
    logic [N-1:0] elig, nd, ne;
    int p;
    nd = '0; ne = '0;
    elig = s_req & ~m_done;
    if (!m_busy) begin
      p = rr_pick(elig, m_ptr);
      if (p >= 0) model_start(p);
    end else if (!m_enable) begin
      m_enable = 1;
      m_waits  = 0;
    end else if (s_ready) begin
      nd[m_owner] = 1'b1;
      if (!m_pwrite) m_rdata = s_prdata;
      m_enable = 0;
      elig[m_owner] = 1'b0;
      p = rr_pick(elig, m_ptr);
      if (p >= 0) model_start(p);
      else m_busy = 0;
    end else begin
      m_waits++;
`ifdef APB_TIMEOUT_EN
      if (m_waits == TO) begin
        nd[m_owner] = 1'b1;
        ne[m_owner] = 1'b1;
        m_busy = 0;
        m_enable = 0;
      end
`endif
    end
    m_done = nd;
    m_err  = ne;
  endtask

  task automatic compare_all();
    check("PSEL",    bus.PSEL,    m_busy);
    check("PENABLE", bus.PENABLE, m_enable);
    check("PWRITE",  bus.PWRITE,  m_pwrite);
    check("PADDR",   bus.PADDR,   m_paddr);
    check("PWDATA",  bus.PWDATA,  m_pwdata);
    check("done",    bus.done,    m_done);
    check("err",     bus.err,     m_err);
    check("rdata",   bus.rdata,   m_rdata);
  endtask

  task automatic tick();
    apply();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    s_req = '0;
    apply();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int order[$];
  int exp_rr[6] = '{0, 2, 3, 0, 2, 3};
  int linger[N];
  int cnt, hold, t_done;
  logic [DW-1:0] exp_rdata;

  initial begin
    s_req = '0; s_wr = '0; s_ready = 1'b1; s_prdata = '0;
    for (int i = 0; i < N; i++) begin
      s_addr[i] = '0; s_wdata[i] = '0; linger[i] = -1;
    end
    apply();
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_psel",  bus.PSEL,    1'b0);
    check("rst_pen",   bus.PENABLE, 1'b0);
    check("rst_done",  bus.done,    4'b0000);
    check("rst_rdata", bus.rdata,   32'h0);
    compare_all();
    rst_n = 1'b1;

    // single write, no wait states
    s_req = 4'b0001; s_wr = 4'b0001; s_addr[0] = 32'h10; s_wdata[0] = 32'hA5A5A5A5;
    tick();
    check("t1_psel",  bus.PSEL,    1'b1);
    check("t1_pen0",  bus.PENABLE, 1'b0);
    check("t1_paddr", bus.PADDR,   32'h10);
    check("t1_pwr",   bus.PWRITE,  1'b1);
    tick();
    check("t1_pen1",  bus.PENABLE, 1'b1);
    check("t1_pwd",   bus.PWDATA,  32'hA5A5A5A5);
    tick();
    check("t1_done",  bus.done,    4'b0001);
    s_req = '0;
    tick();
    check("t1_idle",  bus.PSEL,    1'b0);

    // read with two wait states
    s_req = 4'b0010; s_wr = '0; s_addr[1] = 32'h24; s_prdata = 32'hDEADBEEF; s_ready = 1'b0;
    cnt = 0;
    for (int t = 1; t <= 5; t++) begin
      s_ready = (t == 5);
      tick();
      if (bus.PENABLE) cnt++;
      if (t < 5) check("t2_nodone", bus.done, 4'b0000);
    end
    check("t2_pen_cycles", cnt, 3);
    check("t2_done", bus.done, 4'b0010);
    check("t2_rdata", bus.rdata, 32'hDEADBEEF);
    s_req = '0; s_ready = 1'b1;
    tick();

    // req held past done: hold=1 masked, hold=2 re-requests once
    for (int extra = 1; extra <= 2; extra++) begin
      s_req = 4'b0001; s_wr = 4'b0001; s_addr[0] = 32'h40 + extra;
      cnt = 0; hold = -1;
      for (int t = 0; t < 12; t++) begin
        tick();
        if (bus.done[0]) begin
          cnt++;
          if (hold < 0) hold = extra;
        end
        if (hold == 0) s_req[0] = 1'b0;
        else if (hold > 0) hold--;
      end
      check(extra == 1 ? "mask_hold1" : "mask_hold2", cnt, extra);
    end

    // round-robin from reset with 0,2,3 held
    do_reset();
    s_req = 4'b1101; s_wr = 4'b1101; s_ready = 1'b1;
    s_addr[0] = 32'h100; s_addr[2] = 32'h200; s_addr[3] = 32'h300;
    order.delete();
    for (int t = 1; t <= 13; t++) begin
      tick();
      check("rr_psel", bus.PSEL, 1'b1);
      if (bus.done != '0) order.push_back(first_set(bus.done));
    end
    check("rr_count", order.size(), 6);
    for (int k = 0; k < 6; k++) check("rr_order", (k < order.size()) ? order[k] : -1, exp_rr[k]);
    s_req = '0;
    repeat (4) tick();

    // asynchronous reset during an ACCESS wait state
    s_req = 4'b0100; s_wr = '0; s_addr[2] = 32'h2C; s_ready = 1'b0;
    repeat (3) tick();
    check("ra_in_access", bus.PENABLE, 1'b1);
    rst_n = 1'b0;
    #1;
    check("ra_psel", bus.PSEL,    1'b0);
    check("ra_pen",  bus.PENABLE, 1'b0);
    check("ra_done", bus.done,    4'b0000);
    model_reset();
    s_req = '0; s_ready = 1'b1;
    apply();
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      check("ra_nodone", bus.done, 4'b0000);
    end
    s_req = 4'b1010; s_wr = 4'b1010; s_addr[1] = 32'h111; s_addr[3] = 32'h333;
    tick();
    check("ra_ptr0", bus.PADDR, 32'h111);
    for (int t = 0; t < 8; t++) begin
      s_req = s_req & ~m_done;
      tick();
    end
    s_req = '0;
    tick();

    // stuck PREADY
    s_req = 4'b0010; s_wr = '0; s_addr[1] = 32'h30; s_ready = 1'b0;
    exp_rdata = m_rdata;
    cnt = 0; t_done = -1;
    for (int t = 1; t <= 100; t++) begin
      tick();
      if (bus.done[1]) begin
        cnt++;
        if (t_done < 0) t_done = t;
`ifdef APB_TIMEOUT_EN
        check("to_err", bus.err, 4'b0010);
        check("to_rdata", bus.rdata, exp_rdata);
        s_req = '0;
`endif
      end
    end
`ifdef APB_TIMEOUT_EN
    check("to_count", cnt, 1);
    check("to_cycle", t_done, 2 + TO);
`else
    check("to_nodone", cnt, 0);
    check("to_waiting", bus.PENABLE, 1'b1);
`endif
    s_ready = 1'b1;
    tick();
    s_req = '0;
    repeat (3) tick();

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (s_req[i]) begin
          if (linger[i] > 0) linger[i]--;
          else if (linger[i] == 0) begin
            s_req[i] = 1'b0; linger[i] = -1;
          end else if (m_done[i]) begin
            case ($urandom_range(0, 5))
              4:       linger[i] = 0;
              5:       linger[i] = 1;
              default: s_req[i] = 1'b0;
            endcase
          end
        end else if ($urandom_range(0, 3) == 0) begin
          s_req[i]   = 1'b1;
          s_wr[i]    = 1'($urandom_range(0, 1));
          s_addr[i]  = $urandom;
          s_wdata[i] = $urandom;
        end else begin
          s_wr[i]    = 1'($urandom_range(0, 1));
          s_addr[i]  = $urandom;
          s_wdata[i] = $urandom;
        end
      end
      s_ready  = ($urandom_range(0, 3) != 0);
      s_prdata = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares one APB master port between NUM_REQ local requesters using round-robin arbitration.
- Sequences the APB SETUP/ACCESS phases and honours PREADY wait states.
- Returns read data with a per-requester done pulse.
- Sits between on-chip command sources and the APB bus, driving the same PSEL/PENABLE/PWRITE/PADDR/PWDATA signals the testbench BFM drives.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for PREADY. Used only with APB_TIMEOUT_EN.

Ports:
- apbClk  in  1  bus clock; all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester transfer request; held with its command until done.
- req_write  in  NUM_REQ  1=write, 0=read, per requester.
- req_addr  in  NUM_REQ*APB_ADDR_WIDTH  packed addresses; requester i at slice i.
- req_wdata  in  NUM_REQ*APB_DATA_WIDTH  packed write data.
- done  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- err  out  NUM_REQ  one-cycle error flag, coincident with done.
- rdata  out  APB_DATA_WIDTH  read data of the last completed read.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  APB_DATA_WIDTH  APB write data.
- PRDATA  in  APB_DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, RR pointer 0, any in-flight transfer dropped with no done.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE, any unmasked req at the edge:
  - Grant the winner, latch its write/addr/wdata into PWRITE/PADDR/PWDATA.
  - PSEL=1, PENABLE=0, go to SETUP.
- SETUP: unconditionally PENABLE=1, go to ACCESS.
- ACCESS with PREADY=0: hold all outputs (wait state).
- ACCESS with PREADY=1 at the edge (completion):
  - done[g]=1 for the following cycle.
  - On a read, rdata<=PRDATA. rdata is held until the next read completes; unchanged on writes.
  - PENABLE=0.
  - If another unmasked requester (excluding g) is pending, go straight to SETUP with the new grant; PSEL stays 1.
  - Otherwise PSEL=0 and go to IDLE.
- Latency: req sampled at edge E0 gives PSEL after E0, PENABLE after E0+1, done after E0+2. Each wait state adds 1 cycle.
- Round-robin:
  - Search starts at pointer, ascending, wrapping modulo NUM_REQ.
  - Pointer <= (granted index + 1) mod NUM_REQ on each grant.
- Masking: req[i] is ignored while done[i]=1. The requester must drop req by the next edge, otherwise it is taken as a new request.
- PADDR/PWRITE/PWDATA hold their last values when PSEL=0.
- A req deasserted before done is a protocol violation; the transfer still completes.
- req_* of non-granted requesters may change freely.
- err is always 0 unless APB_TIMEOUT_EN is defined.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - On reaching TIMEOUT_CYCLES, the transfer aborts: done[g]=1 and err[g]=1, rdata unchanged, PSEL=PENABLE=0, go to IDLE.
  - PREADY=1 on the same edge the counter reaches the limit wins, completing normally.
- Undefined: no counter, ACCESS waits indefinitely, err tied to 0.

Decomposition:
- definesPkg:
  - Existing APB_ADDR_WIDTH and APB_DATA_WIDTH.
  - New typedef enum apb_arb_state_e {IDLE, SETUP, ACCESS}.
  - Constant APB_ARB_MAX_REQ=8.
- Sub-module apb_rr_arbiter:
  - Inputs: request vector, mask, pointer.
  - Outputs: one-hot grant, index, valid.
  - Pointer register lives in the parent.

Test Plan:
- Single write: req[0]=1, addr 0x10, wdata 0xA5A5A5A5, PREADY=1 → PSEL rises 1 cycle after req sampled, PENABLE next cycle, done[0] 3 cycles after req, PADDR=0x10, PWRITE=1.
- Read with 2 wait states: req[1] read of 0x24, PRDATA=0xDEADBEEF → PENABLE high 3 cycles, rdata=0xDEADBEEF, done[1] at cycle 5.
- Round-robin: req[0], req[2], req[3] held continuously from reset → grant order 0,2,3,0,2,…, back-to-back with PSEL never dropping between transfers.
- Mask/re-request: req[0] held 1 cycle past done → no duplicate transfer. Held 2 cycles past done → exactly one extra transfer.
- Reset mid-ACCESS: rst=0 while PREADY=0 → PSEL/PENABLE/done go 0 immediately, no done after release, pointer=0.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and PREADY stuck low → done[g]=err[g]=1 after 16 ACCESS cycles, rdata unchanged. Without the macro, no done after 100 cycles.
